// File: rtl/ram_wr_arbiter_pkg.sv
// Shared types and helpers for the RAM write-side controller.
// Holds the FSM state enum and the round-robin one-hot pick function.
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int MAXREQ = 16;
  localparam int PTRMAX = 4;

  // Scans req from ptr upward, wrapping at n; returns a one-hot of the first set bit.
  // Only the low n bits of req are considered (n <= MAXREQ, ptr < n).
  function automatic logic [MAXREQ-1:0] first_from_ptr(
    input logic [MAXREQ-1:0] req,
    input logic [PTRMAX-1:0] ptr,
    input int unsigned       n
  );
    logic [MAXREQ-1:0] pick;
    logic              found;
    int unsigned       idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAXREQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= n) idx = idx - n;
      if (i < n && !found && req[idx[PTRMAX-1:0]]) begin
        pick[idx[PTRMAX-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ram_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: request vector plus pointer in,
// one-hot grant, its index and an any-grant flag out.
module rr_picker
  import ram_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PTRW-1:0] i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [PTRW-1:0] o_idx,
  output logic            o_any
);

  logic [NREQ-1:0] w_grant;

  always_comb begin
    w_grant = NREQ'(first_from_ptr(MAXREQ'(i_req), PTRMAX'(i_ptr), NREQ));
  end

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) o_idx = PTRW'(i);
    end
  end

  assign o_grant = w_grant;
  assign o_any   = |w_grant;

endmodule

// File: rtl/ram_wr_arbiter.sv
// Write-side controller for the two-write-port RAM: round-robin arbitration of
// port 1 between requesters, plus a port-2 clear sequence that zeroes the RAM.
module ram_wr_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 3
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [NREQ-1:0]                     i_req_valid,
  input  logic [NREQ-1:0][ADDRWIDTH-1:0]      i_req_addr,
  input  logic [NREQ-1:0][DATAWIDTH-1:0]      i_req_data,
  output logic [NREQ-1:0]                     o_req_ready,
  input  logic                                i_clr_start,
  output logic                                o_clr_busy,
  output logic                                o_clr_done,
  output logic                                o_en_w1_n,
  output logic [ADDRWIDTH-1:0]                o_addr_w1,
  output logic [DATAWIDTH-1:0]                o_data_w1,
  output logic                                o_en_w2_n,
  output logic [ADDRWIDTH-1:0]                o_addr_w2,
  output logic [DATAWIDTH-1:0]                o_data_w2
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // cnt carries one extra bit so the last address compares unambiguously
  localparam logic [ADDRWIDTH:0] LAST_ADDR = {1'b0, {ADDRWIDTH{1'b1}}};

  state_t                 r_state, w_state_nxt;
  logic [ADDRWIDTH:0]     r_cnt, w_cnt_nxt;
  logic [PTRW-1:0]        r_rr_ptr;
  logic                   r_clr_done;
  logic                   r_en_w1_n, r_en_w2_n;
  logic [ADDRWIDTH-1:0]   r_addr_w1, r_addr_w2;
  logic [DATAWIDTH-1:0]   r_data_w1;

  logic [NREQ-1:0]        w_grant;
  logic [PTRW-1:0]        w_gnt_idx;
  logic                   w_gnt_any;
  logic                   w_arb_en;
  logic                   w_fire;

  rr_picker #(.NREQ(NREQ), .PTRW(PTRW)) u_picker (
    .i_req   (i_req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gnt_idx),
    .o_any   (w_gnt_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_arb_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_clr_start) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end else begin
          w_arb_en = 1'b1;
        end
      end
      CLEAR: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == LAST_ADDR) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_fire      = w_arb_en & w_gnt_any;
  assign o_req_ready = w_arb_en ? w_grant : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_rr_ptr   <= '0;
      r_clr_done <= 1'b0;
      r_en_w1_n  <= 1'b1;
      r_en_w2_n  <= 1'b1;
      r_addr_w1  <= '0;
      r_data_w1  <= '0;
      r_addr_w2  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_clr_done <= (r_state == DONE);
      r_en_w1_n  <= ~w_fire;
      if (w_fire) begin
        r_addr_w1 <= i_req_addr[w_gnt_idx];
        r_data_w1 <= i_req_data[w_gnt_idx];
        r_rr_ptr  <= (w_gnt_idx == PTRW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
      end
      // Grants never happen outside IDLE, so the two enables cannot overlap
      r_en_w2_n <= (r_state != CLEAR);
      if (r_state == CLEAR) r_addr_w2 <= r_cnt[ADDRWIDTH-1:0];
    end
  end

  assign o_clr_busy = (r_state != IDLE);
  assign o_clr_done = r_clr_done;
  assign o_en_w1_n  = r_en_w1_n;
  assign o_addr_w1  = r_addr_w1;
  assign o_data_w1  = r_data_w1;
  assign o_en_w2_n  = r_en_w2_n;
  assign o_addr_w2  = r_addr_w2;
  assign o_data_w2  = '0;

endmodule

// File: tb/tb_ram_wr_arbiter.sv
// Scoreboard bench for ram_wr_arbiter: directed stimulus pushes expected RAM
// writes into queues, a monitor pops and compares whenever a write enable is low.
module tb_ram_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int AW   = 3;

  logic                    clk;
  logic                    rst;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0][AW-1:0] req_addr;
  logic [NREQ-1:0][DW-1:0] req_data;
  logic [NREQ-1:0]         req_ready;
  logic                    clr_start, clr_busy, clr_done;
  logic                    en_w1_n, en_w2_n;
  logic [AW-1:0]           addr_w1, addr_w2;
  logic [DW-1:0]           data_w1, data_w2;

  logic [DW-1:0]           mem [8];
  logic [15:0]             exp_q1[$];
  logic [15:0]             exp_q2[$];
  int                      n_cmp = 0;
  int                      n_bad = 0;

  ram_wr_arbiter #(.NREQ(NREQ), .DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_addr(req_addr),
    .i_req_data(req_data), .o_req_ready(req_ready), .i_clr_start(clr_start),
    .o_clr_busy(clr_busy), .o_clr_done(clr_done), .o_en_w1_n(en_w1_n),
    .o_addr_w1(addr_w1), .o_data_w1(data_w1), .o_en_w2_n(en_w2_n),
    .o_addr_w2(addr_w2), .o_data_w2(data_w2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: port 1 wins when both enables are low
  always @(posedge clk) begin
    if (en_w1_n === 1'b0)      mem[addr_w1] <= data_w1;
    else if (en_w2_n === 1'b0) mem[addr_w2] <= data_w2;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (en_w1_n === 1'b0 && en_w2_n === 1'b0) chk("both_en_low", 32'd1, 32'd0);
    if (en_w1_n === 1'b0) begin
      if (exp_q1.size() == 0) chk("unexpected_w1", {16'd0, 5'd0, addr_w1, data_w1}, 32'hFFFF_FFFF);
      else chk("w1_write", {16'd0, 5'd0, addr_w1, data_w1}, {16'd0, exp_q1.pop_front()});
    end
    if (en_w2_n === 1'b0) begin
      if (exp_q2.size() == 0) chk("unexpected_w2", {16'd0, 5'd0, addr_w2, data_w2}, 32'hFFFF_FFFF);
      else chk("w2_write", {16'd0, 5'd0, addr_w2, data_w2}, {16'd0, exp_q2.pop_front()});
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clr_inputs();
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    clr_start = 1'b0;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst = 1'b1;
    next_cyc();
    next_cyc();
    sample();
    chk("rst_en_w1_n", 32'(en_w1_n), 32'd1);
    chk("rst_en_w2_n", 32'(en_w2_n), 32'd1);
    chk("rst_addr_data", {8'd0, 5'd0, addr_w1, 5'd0, addr_w2, data_w1}, 32'd0);
    chk("rst_data_w2", 32'(data_w2), 32'd0);
    chk("rst_clr_flags", {30'd0, clr_busy, clr_done}, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    next_cyc();
    rst = 1'b0;
  endtask

  // Clear sequence; optionally holds requester 1 valid throughout
  task automatic run_clear(input logic with_req);
    clr_start = 1'b1;
    if (with_req) begin
      req_valid   = 4'b0010;
      req_addr[1] = 3'd2;
      req_data[1] = 8'h3C;
    end
    for (int a = 0; a < 8; a++) exp_q2.push_back({5'd0, 3'(a), 8'h00});
    sample();
    chk("clr_start_ready", 32'(req_ready), 32'd0);
    next_cyc();
    clr_start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      sample();
      chk("clr_busy_hi", 32'(clr_busy), 32'd1);
      chk("clr_ready_zero", 32'(req_ready), 32'd0);
      chk("clr_done_lo", 32'(clr_done), 32'd0);
      next_cyc();
    end
    sample();
    chk("clr_busy_end", 32'(clr_busy), 32'd0);
    chk("clr_done_pulse", 32'(clr_done), 32'd1);
    if (with_req) begin
      chk("post_clr_grant", 32'(req_ready), 32'b0010);
      exp_q1.push_back({5'd0, 3'd2, 8'h3C});
    end
    next_cyc();
    req_valid = '0;
    sample();
    chk("clr_done_once", 32'(clr_done), 32'd0);
    next_cyc();
  endtask

  initial begin
    rst = 1'b1;
    clr_inputs();

    do_reset();

    // Single requester
    req_valid   = 4'b0100;
    req_addr[2] = 3'd5;
    req_data[2] = 8'hA5;
    exp_q1.push_back({5'd0, 3'd5, 8'hA5});
    sample();
    chk("single_ready", 32'(req_ready), 32'b0100);
    next_cyc();
    req_valid = '0;
    sample();
    chk("single_en_w1", 32'(en_w1_n), 32'd0);
    next_cyc();
    sample();
    chk("single_idle_en", 32'(en_w1_n), 32'd1);
    chk("single_hold", {24'd0, data_w1}, 32'h0000_00A5);
    chk("read_5", 32'(mem[5]), 32'h0000_00A5);
    next_cyc();

    // Round robin from reset
    do_reset();
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      for (int j = 0; j < NREQ; j++) begin
        req_addr[j] = 3'(c);
        req_data[j] = 8'(16 * j + c);
      end
      exp_q1.push_back({5'd0, 3'(c), 8'(16 * (c % 4) + c)});
      sample();
      chk("rr_grant", 32'(req_ready), 32'(1 << (c % 4)));
      next_cyc();
    end
    req_valid = '0;
    next_cyc();

    // Preload then clear
    do_reset();
    req_valid = 4'b0001;
    for (int a = 0; a < 8; a++) begin
      req_addr[0] = 3'(a);
      req_data[0] = 8'hFF;
      exp_q1.push_back({5'd0, 3'(a), 8'hFF});
      sample();
      chk("preload_grant", 32'(req_ready), 32'b0001);
      next_cyc();
    end
    req_valid = '0;
    next_cyc();
    next_cyc();
    chk("preload_read3", 32'(mem[3]), 32'h0000_00FF);
    run_clear(1'b0);
    for (int a = 0; a < 8; a++) chk("cleared_read", 32'(mem[a]), 32'd0);

    // Clear versus a simultaneous request
    run_clear(1'b1);
    next_cyc();
    chk("survive_read2", 32'(mem[2]), 32'h0000_003C);
    chk("survive_read0", 32'(mem[0]), 32'd0);

    // Reset mid-clear at cnt = 3
    clr_start = 1'b1;
    for (int a = 0; a < 3; a++) exp_q2.push_back({5'd0, 3'(a), 8'h00});
    next_cyc();
    clr_start = 1'b0;
    next_cyc();
    next_cyc();
    next_cyc();
    rst = 1'b1;
    sample();
    chk("midclr_busy", 32'(clr_busy), 32'd1);
    next_cyc();
    rst = 1'b0;
    sample();
    chk("midclr_no_w2", 32'(en_w2_n), 32'd1);
    chk("midclr_idle", 32'(clr_busy), 32'd0);
    next_cyc();
    sample();
    chk("midclr_still_idle", {30'd0, clr_busy, en_w2_n}, 32'd1);
    next_cyc();

    chk("q1_drained", 32'(exp_q1.size()), 32'd0);
    chk("q2_drained", 32'(exp_q2.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_wr_arbiter.md
# ram_wr_arbiter

Write-side controller for the two-write-port flip-flop RAM. Shares RAM write port 1 between `NREQ` requesters using round-robin arbitration with a valid/ready handshake. Owns RAM write port 2 for a software-triggered clear sequence that zeroes every RAM location. All RAM-facing outputs are registered, and the block never drives both write enables low in the same cycle, because the RAM honours only port 1 in that case.

## Interface
- `NREQ`, 4, number of write requesters (2..16)
- `DATAWIDTH`, 8, RAM data width
- `ADDRWIDTH`, 3, RAM address width; depth = 2**ADDRWIDTH
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  one clock; reset is synchronous and active-high
- `req_valid`  in  NREQ  per-requester write request
- `req_addr`  in  NREQ x ADDRWIDTH  per-requester write address
- `req_data`  in  NREQ x DATAWIDTH  per-requester write data
- `req_ready`  out  NREQ  one-hot grant; a transfer occurs when valid && ready
- `clr_start`  in  1  single-cycle pulse that starts a RAM clear
- `clr_busy`  out  1  high while a clear is in progress
- `clr_done`  out  1  single-cycle pulse when the clear completes
- `en_w1_n`  out  1  RAM write port 1 enable, active-low
- `addr_w1`  out  ADDRWIDTH  RAM write port 1 address
- `data_w1`  out  DATAWIDTH  RAM write port 1 data
- `en_w2_n`  out  1  RAM write port 2 enable, active-low
- `addr_w2`  out  ADDRWIDTH  RAM write port 2 address
- `data_w2`  out  DATAWIDTH  RAM write port 2 data; always 0

## Operation
- FSM states: IDLE, CLEAR, DONE.
- IDLE:
  - Arbitration scans `req_valid` starting at `rr_ptr` and wrapping modulo `NREQ`. The first valid requester is granted.
  - `req_ready` is combinational from `req_valid`, `rr_ptr` and state, so a grant completes the handshake in the same cycle.
  - On a grant to requester g, `rr_ptr` moves to (g+1) mod `NREQ`. With no grant, `rr_ptr` holds.
- `clr_start` in IDLE:
  - Has priority over requesters: `req_ready` is all-zero that cycle.
  - Next state is CLEAR with `cnt` = 0.
- CLEAR:
  - `req_ready` is all-zero.
  - Each cycle issues one port-2 write of 0 to address `cnt`, then increments `cnt`.
  - After `cnt` = depth-1 is issued, next state is DONE.
- DONE: lasts one cycle, then returns to IDLE. `req_ready` is all-zero.
- `clr_start` is ignored outside IDLE.
- `clr_busy` = (state != IDLE).
- `clr_done` is registered: high for exactly the one cycle after the state leaves DONE.
- `en_w1_n` and `en_w2_n` are never low together.
- `cnt` is ADDRWIDTH+1 bits wide, so depth-1 is detected without wrap ambiguity.

## Timing
- Reset values (one cycle after `rst` is sampled high):
  - state = IDLE, `rr_ptr` = 0, `cnt` = 0
  - `en_w1_n` = 1, `en_w2_n` = 1
  - `addr_w1`/`addr_w2`/`data_w1`/`data_w2` = 0
  - `clr_done` = 0, `req_ready` = 0
- Write latency: a handshake in cycle N drives `en_w1_n` = 0, `addr_w1` and `data_w1` in cycle N+1. The RAM captures the write at the end of cycle N+1.
- With no grant, `en_w1_n` = 1 next cycle and `addr_w1`/`data_w1` hold their previous values.
- Clear timing: `clr_start` in cycle N gives:
  - `clr_busy` = 1 from N+1 through N+depth+1
  - port-2 writes to addresses 0..depth-1 in cycles N+2..N+depth+1
  - `clr_done` = 1 in cycle N+depth+2
  - Requesters can be granted again from cycle N+depth+2.
- Throughput: one requester write per cycle in IDLE. A continuously valid requester waits at most NREQ-1 grants.
- `rst` mid-clear aborts immediately with no further writes. RAM contents are left partially cleared; the RAM's own reset covers this case.

## Structure
- The package `ram_ctrl_pkg` holds:
  - the `state_t` enum (IDLE, CLEAR, DONE)
  - a `first_from_ptr` function: round-robin one-hot pick, parameterised by width
- One sub-module is natural: `rr_picker` (combinational; `NREQ` request vector plus pointer in, one-hot grant and index out).
- The top level holds the FSM, `cnt`, `rr_ptr` and the output registers.

## Test plan
- Reset: `rst` high for 2 cycles → all outputs at reset values; `en_w1_n` = `en_w2_n` = 1.
- Single requester: req 2 valid with addr 5, data 0xA5 → `req_ready` = 0b0100 the same cycle. Next cycle `en_w1_n` = 0, `addr_w1` = 5, `data_w1` = 0xA5. A RAM read of address 5 then returns 0xA5.
- Round robin: all 4 requesters held valid for 8 cycles from reset → grant order 0,1,2,3,0,1,2,3.
- Clear (`ADDRWIDTH` = 3):
  - Preload all 8 addresses with 0xFF, then pulse `clr_start`.
  - Expected: 8 consecutive port-2 writes to addresses 0..7, `clr_busy` high for 9 cycles, and a `clr_done` pulse.
  - All reads then return 0.
- Clear vs requests: `clr_start` and req 1 valid in the same cycle → `req_ready` = 0 through the clear. Req 1 is granted in the cycle `clr_done` is high, and its data survives the clear.
- Reset mid-clear: `rst` at `cnt` = 3 → no port-2 write in the following cycle, and state is IDLE with `clr_busy` = 0 after reset.
